// File: rtl/chess_kbd_pkg.sv
// Shared definitions for the chess keyboard move-entry slice: PS/2 scan codes,
// key classes, entry FSM states and the 6-bit board square type.
package chess_kbd_pkg;

    // Frame marker that precedes the break code
    localparam logic [7:0] SC_BREAK  = 8'hF0;

    // File keys a..h
    localparam logic [7:0] SC_FILE_A = 8'h1C;
    localparam logic [7:0] SC_FILE_B = 8'h32;
    localparam logic [7:0] SC_FILE_C = 8'h21;
    localparam logic [7:0] SC_FILE_D = 8'h23;
    localparam logic [7:0] SC_FILE_E = 8'h24;
    localparam logic [7:0] SC_FILE_F = 8'h2B;
    localparam logic [7:0] SC_FILE_G = 8'h34;
    localparam logic [7:0] SC_FILE_H = 8'h33;

    // Rank keys 1..8
    localparam logic [7:0] SC_RANK_1 = 8'h16;
    localparam logic [7:0] SC_RANK_2 = 8'h1E;
    localparam logic [7:0] SC_RANK_3 = 8'h26;
    localparam logic [7:0] SC_RANK_4 = 8'h25;
    localparam logic [7:0] SC_RANK_5 = 8'h2E;
    localparam logic [7:0] SC_RANK_6 = 8'h36;
    localparam logic [7:0] SC_RANK_7 = 8'h3D;
    localparam logic [7:0] SC_RANK_8 = 8'h3E;

    // Editing / control keys
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;

    typedef enum logic [2:0] {
        KC_FILE  = 3'd0,
        KC_RANK  = 3'd1,
        KC_ENTER = 3'd2,
        KC_BKSP  = 3'd3,
        KC_ESC   = 3'd4,
        KC_OTHER = 3'd5
    } key_class_e;

    typedef enum logic [2:0] {
        S_FFILE   = 3'd0,
        S_FRANK   = 3'd1,
        S_TFILE   = 3'd2,
        S_TRANK   = 3'd3,
        S_CONFIRM = 3'd4,
        S_OUT     = 3'd5
    } entry_state_e;

    // Square index = rank*8 + file, so the rank sits in the top three bits
    typedef logic [5:0] square_t;

    function automatic square_t make_square(input logic [2:0] rank, input logic [2:0] file);
        return {rank, file};
    endfunction

endpackage

// File: rtl/scan_decode.sv
// Maps one scan-code byte onto a key class and a 0..7 value (file or rank).
module scan_decode
    import chess_kbd_pkg::*;
(
    input  logic [7:0]  code,
    output key_class_e  key_class,
    output logic [2:0]  key_value
);

    // Pure lookup: anything not in the table is reported as OTHER
    always_comb begin
        key_class = KC_OTHER;
        key_value = 3'd0;
        case (code)
            SC_FILE_A: begin key_class = KC_FILE;  key_value = 3'd0; end
            SC_FILE_B: begin key_class = KC_FILE;  key_value = 3'd1; end
            SC_FILE_C: begin key_class = KC_FILE;  key_value = 3'd2; end
            SC_FILE_D: begin key_class = KC_FILE;  key_value = 3'd3; end
            SC_FILE_E: begin key_class = KC_FILE;  key_value = 3'd4; end
            SC_FILE_F: begin key_class = KC_FILE;  key_value = 3'd5; end
            SC_FILE_G: begin key_class = KC_FILE;  key_value = 3'd6; end
            SC_FILE_H: begin key_class = KC_FILE;  key_value = 3'd7; end
            SC_RANK_1: begin key_class = KC_RANK;  key_value = 3'd0; end
            SC_RANK_2: begin key_class = KC_RANK;  key_value = 3'd1; end
            SC_RANK_3: begin key_class = KC_RANK;  key_value = 3'd2; end
            SC_RANK_4: begin key_class = KC_RANK;  key_value = 3'd3; end
            SC_RANK_5: begin key_class = KC_RANK;  key_value = 3'd4; end
            SC_RANK_6: begin key_class = KC_RANK;  key_value = 3'd5; end
            SC_RANK_7: begin key_class = KC_RANK;  key_value = 3'd6; end
            SC_RANK_8: begin key_class = KC_RANK;  key_value = 3'd7; end
            SC_ENTER:  begin key_class = KC_ENTER; key_value = 3'd0; end
            SC_BKSP:   begin key_class = KC_BKSP;  key_value = 3'd0; end
            SC_ESC:    begin key_class = KC_ESC;   key_value = 3'd0; end
            default:   begin key_class = KC_OTHER; key_value = 3'd0; end
        endcase
    end

endmodule

// File: rtl/move_entry.sv
// Keyboard move entry: collects from-file, from-rank, to-file, to-rank (and
// optionally Enter) from PS/2 frames and presents the move until acknowledged.
module move_entry
    import chess_kbd_pkg::*;
#(
    parameter bit REQUIRE_CONFIRM = 1'b1
)
(
    input  logic        clk50,
    input  logic        resetn,
    input  logic        scan_ready,
    input  logic [7:0]  scan_code1,
    input  logic [7:0]  scan_code2,
    input  logic [7:0]  scan_code3,
    output logic [5:0]  move_from,
    output logic [5:0]  move_to,
    output logic        move_valid,
    input  logic        move_ack,
    output logic [2:0]  entry_state,
    output logic        key_err
);

    entry_state_e state;
    entry_state_e state_next;
    square_t      from_q;
    square_t      from_next;
    square_t      to_q;
    square_t      to_next;
    logic         err_next;
    logic         prev_ready;
    logic         key_event;
    logic         frame_ok;
    key_class_e   key_class;
    logic [2:0]   key_value;
    logic         commit_req;
    square_t      commit_to;

    scan_decode u_decode (
        .code      (scan_code1),
        .key_class (key_class),
        .key_value (key_value)
    );

    // The front end is clocked from a divided clk50, so scan_ready is already
    // synchronous; a rising edge on it marks exactly one key event.
    assign key_event = scan_ready & ~prev_ready;
    assign frame_ok  = (scan_code2 == SC_BREAK) && (scan_code1 == scan_code3);

    // State and datapath registers; prev_ready resets high so a frame flag
    // already asserted at reset release is not mistaken for a new key.
    always_ff @(posedge clk50 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_FFILE;
            from_q     <= '0;
            to_q       <= '0;
            key_err    <= 1'b0;
            prev_ready <= 1'b1;
        end else begin
            state      <= state_next;
            from_q     <= from_next;
            to_q       <= to_next;
            key_err    <= err_next;
            prev_ready <= scan_ready;
        end
    end

    // Next-state, field latching and error decision for each key event
    always_comb begin
        state_next = state;
        from_next  = from_q;
        to_next    = to_q;
        err_next   = 1'b0;
        commit_req = 1'b0;
        commit_to  = to_q;

        if (state == S_OUT) begin
            if (move_ack) begin
                state_next = S_FFILE;
            end
        end else if (state > S_OUT) begin
            state_next = S_FFILE;
        end else if (key_event) begin
            if (!frame_ok) begin
                err_next = 1'b1;
            end else begin
                case (key_class)
                    KC_ESC: begin
                        state_next = S_FFILE;
                        from_next  = '0;
                        to_next    = '0;
                    end
                    KC_BKSP: begin
                        case (state)
                            S_FRANK:   state_next = S_FFILE;
                            S_TFILE:   state_next = S_FRANK;
                            S_TRANK:   state_next = S_TFILE;
                            S_CONFIRM: state_next = S_TRANK;
                            default:   state_next = state;
                        endcase
                    end
                    KC_FILE: begin
                        case (state)
                            S_FFILE: begin
                                state_next = S_FRANK;
                                from_next  = make_square(from_q[5:3], key_value);
                            end
                            S_TFILE: begin
                                state_next = S_TRANK;
                                to_next    = make_square(to_q[5:3], key_value);
                            end
                            default: err_next = 1'b1;
                        endcase
                    end
                    KC_RANK: begin
                        case (state)
                            S_FRANK: begin
                                state_next = S_TFILE;
                                from_next  = make_square(key_value, from_q[2:0]);
                            end
                            S_TRANK: begin
                                to_next = make_square(key_value, to_q[2:0]);
                                if (REQUIRE_CONFIRM) begin
                                    state_next = S_CONFIRM;
                                end else begin
                                    commit_req = 1'b1;
                                    commit_to  = make_square(key_value, to_q[2:0]);
                                end
                            end
                            default: err_next = 1'b1;
                        endcase
                    end
                    KC_ENTER: begin
                        if (state == S_CONFIRM) begin
                            commit_req = 1'b1;
                            commit_to  = to_q;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    default: err_next = 1'b1;
                endcase

                // A null move is refused; the source square is kept so only
                // the destination has to be retyped.
                if (commit_req) begin
                    if (from_q == commit_to) begin
                        err_next   = 1'b1;
                        state_next = S_TFILE;
                    end else begin
                        state_next = S_OUT;
                    end
                end
            end
        end
    end

    // Outputs are straight decodes of the registered state and fields
    always_comb begin
        entry_state = state;
        move_valid  = (state == S_OUT);
        move_from   = from_q;
        move_to     = to_q;
    end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 Parameter REQUIRE_CONFIRM, default 1, meaning 1 = Enter needed to commit a move, 0 = commit on the to-rank key.
REQ-002 Port clk50, input, 1, system clock (50 MHz); the keyboard front end runs from a divided copy of this clock, so no synchronizer is used.
REQ-003 Port resetn, input, 1, reset, asynchronous and active-low.
REQ-004 Port scan_ready, input, 1, frame-complete flag from the keyboard front end; high for 2 or more clk50 cycles per frame.
REQ-005 Port scan_code1, input, 8, make code of the frame.
REQ-006 Port scan_code2, input, 8, second byte of the frame (break prefix).
REQ-007 Port scan_code3, input, 8, break code of the frame.
REQ-008 Port move_from, output, 6, source square, index = rank*8 + file, a1 = 0, h8 = 63.
REQ-009 Port move_to, output, 6, destination square, same encoding.
REQ-010 Port move_valid, output, 1, move available; held until acknowledged.
REQ-011 Port move_ack, input, 1, consumer accepts the move.
REQ-012 Port entry_state, output, 3, current FSM state, for display.
REQ-013 Port key_err, output, 1, one-cycle pulse on a rejected key.

Function
REQ-014 Key event: one cycle, on the clk50 cycle where scan_ready=1 and the registered previous scan_ready=0; no other cycle yields an event.
REQ-015 Valid frame: scan_code2 = 8'hF0 and scan_code1 = scan_code3. On an invalid frame the state is unchanged and key_err pulses.
REQ-016 Key classes, decoded from scan_code1:
- file: a..h = 1C,32,21,23,24,2B,34,33, values 0..7
- rank: 1..8 = 16,1E,26,25,2E,36,3D,3E, values 0..7
- ENTER = 5A, BKSP = 66, ESC = 76
- all other codes are class OTHER
REQ-017 FSM states and encodings: S_FFILE=0, S_FRANK=1, S_TFILE=2, S_TRANK=3, S_CONFIRM=4, S_OUT=5. entry_state equals the state register.
REQ-018 Transitions on a valid key event:
- file key in S_FFILE -> S_FRANK; file key in S_TFILE -> S_TRANK
- rank key in S_FRANK -> S_TFILE; rank key in S_TRANK -> S_CONFIRM (REQUIRE_CONFIRM=1) or commit (REQUIRE_CONFIRM=0)
- ENTER in S_CONFIRM -> commit
- each accepted file/rank key latches its value into the corresponding field of move_from or move_to
REQ-019 BKSP steps back one state (S_FRANK->S_FFILE, S_TFILE->S_FRANK, S_TRANK->S_TFILE, S_CONFIRM->S_TRANK); in S_FFILE it is a no-op with no error.
REQ-020 ESC in states 0..4 -> S_FFILE, with move_from and move_to cleared to 0.
REQ-021 A wrong-class key (including OTHER, or ENTER outside S_CONFIRM) leaves the state unchanged and pulses key_err in the cycle after the event.
REQ-022 Commit when move_from = move_to: key_err pulses and the FSM goes to S_TFILE, keeping move_from.
REQ-023 Commit with distinct squares: the FSM goes to S_OUT and move_valid=1 one cycle after the event; move_from and move_to stay stable while move_valid=1.
REQ-024 In S_OUT all key events are ignored with no key_err; move_ack=1 -> move_valid=0 and state S_FFILE on the next cycle.
REQ-025 A key event in the same cycle as move_ack in S_OUT is dropped.
REQ-026 move_ack outside S_OUT is ignored.
REQ-027 Latency from key event to the state, output and key_err update is exactly 1 clk50 cycle.

Reset
REQ-028 resetn=0 asynchronously forces: state S_FFILE, move_from=0, move_to=0, move_valid=0, key_err=0, previous-scan_ready register=1. Setting the previous value to 1 prevents a spurious event if scan_ready is high at release.
REQ-029 Reset asserted mid-entry or while move_valid=1 discards the pending move; no move_valid is produced after release until a new, complete entry.

Structure
REQ-030 Shared package chess_kbd_pkg holds the scan-code constants, the key-class enum, the FSM state enum and the 6-bit square type.
REQ-031 A combinational sub-module scan_decode maps a byte to {class, 3-bit value}; move_entry instantiates it once.

Verification
REQ-032 Bench scenario, normal move: keys e,2,e,4,ENTER, each frame {code,F0,code} -> move_valid=1 with move_from=12, move_to=28; held until move_ack, then entry_state=0.
REQ-033 Bench scenario, no confirm: REQUIRE_CONFIRM=0, keys g,1,f,3 -> move_valid=1 one cycle after the '3' event, with move_from=6, move_to=21.
REQ-034 Bench scenario, editing: keys a,7,BKSP,8,h,1,ESC -> entry_state=0, moves cleared; then keys a,1,a,1,ENTER -> key_err pulse and entry_state=2.
REQ-035 Bench scenario, errors: frame {1C,E0,1C} -> key_err and no state change; key 'x'(22) in S_FFILE -> key_err; scan_ready held high for 4 cycles -> exactly one event.
REQ-036 Bench scenario, handshake: while move_valid=1, send key d -> ignored; move_ack together with a key event -> key dropped, entry_state=0.
REQ-037 Bench scenario, reset: resetn pulsed low in S_TRANK and again while move_valid=1 -> all outputs 0 and entry_state=0 immediately, without waiting for a clock edge.
